// File: rtl/axilwb_arbiter.sv
// axilwb_arbiter: round-robin merge of two pipelined Wishbone masters onto
// one slave bus, with outstanding tracking and bus-timeout abort.
module axilwb_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 26,
  parameter int LGOUT   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            i_clk,
  input  logic            i_axi_reset_n,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_idata,
  output logic [DW-1:0]   o_wb_idata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LGOUT:0] FULL = {1'b1, {LGOUT{1'b0}}};
  localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, ABORT} state_t;

  state_t         state, state_nx;
  logic           last_b, last_b_nx;
  logic [LGOUT:0] outstanding, outstanding_nx;
  logic [TW-1:0]  timer, timer_nx;

  logic own_a, own_b, owner_cyc, arb;
  logic bus_cyc, bus_stb, cnt_full, out_nz;
  logic accept, ack_rt, err_rt, tmo;

  // last_b doubles as the current owner while in OWN_x or ABORT
  assign own_a     = (state == OWN_A);
  assign own_b     = (state == OWN_B);
  assign owner_cyc = last_b ? i_b_cyc : i_a_cyc;
  assign out_nz    = (outstanding != '0);
  assign cnt_full  = (outstanding == FULL);

  assign bus_cyc = i_axi_reset_n &&
                   ((own_a && i_a_cyc) || (own_b && i_b_cyc));
  assign bus_stb = bus_cyc && !cnt_full &&
                   (own_b ? i_b_stb : i_a_stb);
  assign accept  = bus_stb && !i_wb_stall;
  assign ack_rt  = i_wb_ack && bus_cyc && out_nz;
  assign err_rt  = i_wb_err && bus_cyc && out_nz;
  assign tmo     = bus_cyc && out_nz && (timer == TMAX);

  always_ff @(posedge i_clk) begin
    if (!i_axi_reset_n) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      outstanding <= '0;
      timer       <= '0;
    end else begin
      state       <= state_nx;
      last_b      <= last_b_nx;
      outstanding <= outstanding_nx;
      timer       <= timer_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    last_b_nx      = last_b;
    outstanding_nx = outstanding;
    timer_nx       = timer;
    arb            = 1'b0;

    unique case (state)
      IDLE: arb = 1'b1;
      OWN_A, OWN_B: begin
        if (tmo || err_rt)
          state_nx = ABORT;
        else if (!owner_cyc)
          arb = 1'b1;
      end
      ABORT: arb = !owner_cyc;
    endcase

    if (arb) begin
      if (i_a_cyc && (!i_b_cyc || last_b)) begin
        state_nx  = OWN_A;
        last_b_nx = 1'b0;
      end else if (i_b_cyc) begin
        state_nx  = OWN_B;
        last_b_nx = 1'b1;
      end else begin
        state_nx  = IDLE;
      end
    end

    // losing the bus for any reason forgets all in-flight requests
    if (tmo || err_rt || !bus_cyc)
      outstanding_nx = '0;
    else if (accept && !ack_rt)
      outstanding_nx = outstanding + 1'b1;
    else if (!accept && ack_rt)
      outstanding_nx = outstanding - 1'b1;

    if (!out_nz || !bus_cyc || i_wb_ack || i_wb_err || tmo)
      timer_nx = '0;
    else
      timer_nx = timer + 1'b1;
  end

  always_comb begin
    o_wb_cyc   = bus_cyc;
    o_wb_stb   = bus_stb;
    o_wb_we    = own_b ? i_b_we   : i_a_we;
    o_wb_addr  = own_b ? i_b_addr : i_a_addr;
    o_wb_data  = own_b ? i_b_data : i_a_data;
    o_wb_sel   = own_b ? i_b_sel  : i_a_sel;
    o_wb_idata = i_wb_idata;

    o_a_stall = own_a ? (i_wb_stall || cnt_full) : 1'b1;
    o_b_stall = own_b ? (i_wb_stall || cnt_full) : 1'b1;
    o_a_ack   = own_a && ack_rt;
    o_b_ack   = own_b && ack_rt;
    o_a_err   = own_a && (err_rt || tmo);
    o_b_err   = own_b && (err_rt || tmo);
  end

endmodule

// File: tb/tb_axilwb_arbiter.sv
// tb_axilwb_arbiter: directed checks of grant order, routing,
// outstanding limit, timeout, slave error and mid-transfer reset.
module tb_axilwb_arbiter;

  localparam int DW = 32;
  localparam int AW = 26;

  logic            i_clk = 1'b0;
  logic            i_axi_reset_n;
  logic            i_a_cyc, i_a_stb, i_a_we;
  logic [AW-1:0]   i_a_addr;
  logic [DW-1:0]   i_a_data;
  logic [DW/8-1:0] i_a_sel;
  logic            o_a_stall, o_a_ack, o_a_err;
  logic            i_b_cyc, i_b_stb, i_b_we;
  logic [AW-1:0]   i_b_addr;
  logic [DW-1:0]   i_b_data;
  logic [DW/8-1:0] i_b_sel;
  logic            o_b_stall, o_b_ack, o_b_err;
  logic            o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0]   o_wb_addr;
  logic [DW-1:0]   o_wb_data;
  logic [DW/8-1:0] o_wb_sel;
  logic            i_wb_stall, i_wb_ack, i_wb_err;
  logic [DW-1:0]   i_wb_idata;
  logic [DW-1:0]   o_wb_idata;

  int errors = 0;
  int checks = 0;

  axilwb_arbiter #(
    .DW(DW), .AW(AW), .LGOUT(4), .TIMEOUT(255)
  ) dut (
    .i_clk(i_clk), .i_axi_reset_n(i_axi_reset_n),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we),
    .i_a_addr(i_a_addr), .i_a_data(i_a_data), .i_a_sel(i_a_sel),
    .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we),
    .i_b_addr(i_b_addr), .i_b_data(i_b_data), .i_b_sel(i_b_sel),
    .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_idata(i_wb_idata), .o_wb_idata(o_wb_idata)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int acc, err_cnt, err_at, ack_cnt, max_out;

  initial begin
    i_axi_reset_n = 1'b0;
    i_a_cyc = 0; i_a_stb = 0; i_a_we = 0;
    i_a_addr = '0; i_a_data = '0; i_a_sel = '1;
    i_b_cyc = 0; i_b_stb = 0; i_b_we = 0;
    i_b_addr = '0; i_b_data = '0; i_b_sel = '1;
    i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0;
    i_wb_idata = 32'h1234_5678;
    tick(); tick();
    i_axi_reset_n = 1'b1;
    #1;
    chk("rst_cyc", o_wb_cyc, 0);
    chk("rst_a_stall", o_a_stall, 1);
    chk("rst_b_stall", o_b_stall, 1);
    chk("idata_pass", o_wb_idata, 32'h1234_5678);

    // 1: single read from A
    tick();
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 26'h10;
    #1;
    chk("t1_cyc_lat", o_wb_cyc, 0);
    tick();
    #1;
    chk("t1_cyc", o_wb_cyc, 1);
    chk("t1_stb", o_wb_stb, 1);
    chk("t1_addr", o_wb_addr, 26'h10);
    chk("t1_a_stall", o_a_stall, 0);
    chk("t1_b_stall", o_b_stall, 1);
    tick();
    i_a_stb = 0; i_wb_ack = 1;
    #1;
    chk("t1_a_ack", o_a_ack, 1);
    chk("t1_b_ack", o_b_ack, 0);
    tick();
    i_wb_ack = 0; i_a_cyc = 0;
    #1;
    chk("t1_a_ack_once", o_a_ack, 0);
    chk("t1_cyc_drop", o_wb_cyc, 0);
    tick();

    // 2: tie after reset, handoff gap, alternation
    i_axi_reset_n = 0;
    tick();
    i_axi_reset_n = 1;
    i_a_cyc = 1; i_b_cyc = 1;
    i_b_addr = 26'h20; i_b_we = 1;
    tick();
    #1;
    chk("t2_a_first", o_a_stall, 0);
    chk("t2_b_wait", o_b_stall, 1);
    chk("t2_cyc_a", o_wb_cyc, 1);
    i_a_cyc = 0;
    #1;
    chk("t2_gap", o_wb_cyc, 0);
    tick();
    #1;
    chk("t2_b_owns", o_b_stall, 0);
    chk("t2_a_stalled", o_a_stall, 1);
    chk("t2_cyc_b", o_wb_cyc, 1);
    chk("t2_addr_b", o_wb_addr, 26'h20);
    chk("t2_we_b", o_wb_we, 1);
    i_b_cyc = 0;
    tick();
    i_a_cyc = 1; i_b_cyc = 1;
    tick();
    #1;
    chk("t2_alt_a", o_a_stall, 0);
    chk("t2_alt_b", o_b_stall, 1);
    i_a_cyc = 0; i_b_cyc = 0;
    tick(); tick();

    // 3: B fills outstanding limit then times out
    i_b_cyc = 1; i_b_we = 1;
    tick();
    acc = 0; err_cnt = 0; err_at = -1;
    for (int n = 0; n < 320; n++) begin
      i_b_stb = (n < 20);
      #1;
      if (o_wb_stb && !i_wb_stall) acc++;
      if (n == 19) begin
        chk("t3_full_stall", o_b_stall, 1);
        chk("t3_full_stb", o_wb_stb, 0);
      end
      if (o_b_err) begin
        err_cnt++;
        err_at = n;
      end
      tick();
    end
    chk("t3_accepted", acc, 16);
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_err_at", err_at, 256);
    #1;
    chk("t3_abort_cyc", o_wb_cyc, 0);
    chk("t3_abort_stall", o_b_stall, 1);
    i_b_cyc = 0;
    tick();
    #1;
    chk("t3_idle_cyc", o_wb_cyc, 0);

    // 4: slave error on second of three requests
    i_b_cyc = 1;
    tick();
    i_b_stb = 1; i_b_addr = 26'h1;
    tick();
    i_b_addr = 26'h2; i_wb_ack = 1;
    #1;
    chk("t4_ack1", o_b_ack, 1);
    tick();
    i_b_addr = 26'h3; i_wb_ack = 0; i_wb_err = 1;
    #1;
    chk("t4_err", o_b_err, 1);
    chk("t4_err_a", o_a_err, 0);
    tick();
    i_b_stb = 0; i_wb_err = 0; i_wb_ack = 1;
    #1;
    chk("t4_stray_ack", o_b_ack, 0);
    chk("t4_abort_cyc", o_wb_cyc, 0);
    chk("t4_err_once", o_b_err, 0);
    tick();
    i_wb_ack = 0; i_b_cyc = 0;
    tick();

    // 5: back-to-back writes acked in the accept cycle
    i_a_cyc = 1; i_a_we = 1;
    tick();
    ack_cnt = 0; max_out = 0;
    for (int k = 0; k < 10; k++) begin
      i_a_stb  = (k < 8);
      i_a_data = 32'hdead_0000 + k;
      i_wb_ack = (k >= 1);
      #1;
      if (o_a_ack) ack_cnt++;
      if (k == 3) chk("t5_data", o_wb_data, 32'hdead_0003);
      if (int'(dut.outstanding) > max_out) max_out = int'(dut.outstanding);
      tick();
    end
    chk("t5_acks", ack_cnt, 8);
    chk("t5_max_out", max_out, 1);
    i_wb_ack = 0; i_a_cyc = 0; i_a_we = 0;
    tick();

    // 6: reset while B owns with three outstanding
    i_b_cyc = 1;
    tick();
    i_b_stb = 1;
    tick(); tick(); tick();
    i_b_stb = 0; i_a_cyc = 1;
    i_axi_reset_n = 0; i_wb_ack = 1;
    #1;
    chk("t6_rst_cyc", o_wb_cyc, 0);
    chk("t6_rst_ack", o_b_ack, 0);
    tick();
    i_axi_reset_n = 1;
    #1;
    chk("t6_post_cyc", o_wb_cyc, 0);
    chk("t6_post_ack", o_b_ack, 0);
    chk("t6_post_err", o_b_err, 0);
    tick();
    #1;
    chk("t6_a_wins", o_a_stall, 0);
    chk("t6_b_waits", o_b_stall, 1);
    chk("t6_stray_ack", o_a_ack, 0);
    i_wb_ack = 0; i_a_cyc = 0; i_b_cyc = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
